regfile_sb: RTL

//  Next-generation datapath register file: 2 write ports, NREAD combinational read ports,

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_sb_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 66 ++++++
 rtl/regfile_sb.sv | 83 ++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, bypass-select encoding and flattened-port lane helper
// for the regfile_sb register file slice.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_REGBITS = 4;
  localparam int unsigned DEF_NREAD   = 2;

  typedef enum logic [1:0] {
    BYP_RAM,
    BYP_WD0,
    BYP_WD1,
    BYP_ZERO
  } byp_sel_e;

  // Low bit index of lane `lane` in a flattened bus of `w`-bit lanes.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Issue/writeback/read bus of regfile_sb; master = datapath, slave = register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned REGBITS = DEF_REGBITS,
  parameter int unsigned NREAD   = DEF_NREAD
);

  logic                       we0;
  logic [REGBITS-1:0]         wa0;
  logic [WIDTH-1:0]           wd0;
  logic                       we1;
  logic [REGBITS-1:0]         wa1;
  logic [WIDTH-1:0]           wd1;
  logic [NREAD*REGBITS-1:0]   ra;
  logic [NREAD*WIDTH-1:0]     rd;
  logic                       issue;
  logic [REGBITS-1:0]         issue_wa;
  logic [NREAD-1:0]           busy;
  logic [REGBITS:0]           pend_cnt;

  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra, issue, issue_wa,
    input  rd, busy, pend_cnt
  );

  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra, issue, issue_wa,
    output rd, busy, pend_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, set by issue and
// cleared by writeback (issue wins on collision), plus busy lookup and count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned REGBITS  = DEF_REGBITS,
  parameter int unsigned NREAD    = DEF_NREAD,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0_i,
  input  logic [REGBITS-1:0]       wa0_i,
  input  logic                     we1_i,
  input  logic [REGBITS-1:0]       wa1_i,
  input  logic                     issue_i,
  input  logic [REGBITS-1:0]       issue_wa_i,
  input  logic [NREAD*REGBITS-1:0] ra_i,
  output logic [NREAD-1:0]         busy_o,
  output logic [REGBITS:0]         pend_cnt_o
);

  localparam int unsigned DEPTH = 1 << REGBITS;

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [REGBITS:0] cnt_q, cnt_d;
  logic             issue_ok;

  assign issue_ok = issue_i && !(ZERO_REG && (issue_wa_i == '0));

  always_comb begin
    pend_d = pend_q;
    if (we0_i)    pend_d[wa0_i]      = 1'b0;
    if (we1_i)    pend_d[wa1_i]      = 1'b0;
    if (issue_ok) pend_d[issue_wa_i] = 1'b1;
    // Count is the popcount of the next vector, so it tracks pending exactly
    // without separate inc/dec bookkeeping for double retires.
    cnt_d = '0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      cnt_d = cnt_d + (REGBITS+1)'(pend_d[a]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt_o = cnt_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_busy
    logic [REGBITS-1:0] a;
    logic               fwd;
    assign a   = ra_i[lane_lo(i, REGBITS) +: REGBITS];
    assign fwd = BYPASS && ((we0_i && (wa0_i == a)) || (we1_i && (wa1_i == a)))
                 && !(issue_i && (issue_wa_i == a));
    assign busy_o[i] = pend_q[a] && !fwd;
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-write, NREAD-read register file with optional write->read bypass,
// optional hardwired r0 and an integrated pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned REGBITS  = DEF_REGBITS,
  parameter int unsigned NREAD    = DEF_NREAD,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_sb_if.slave bus
);

  localparam int unsigned DEPTH = 1 << REGBITS;

  logic [WIDTH-1:0] ram_q [DEPTH];
  logic             wr0_ok, wr1_ok;

  assign wr0_ok = bus.we0 && !(ZERO_REG && (bus.wa0 == '0));
  assign wr1_ok = bus.we1 && !(ZERO_REG && (bus.wa1 == '0));

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned a = 0; a < DEPTH; a++) ram_q[a] <= '0;
    end else begin
      if (wr0_ok) ram_q[bus.wa0] <= bus.wd0;
      if (wr1_ok) ram_q[bus.wa1] <= bus.wd1;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [REGBITS-1:0] a;
    logic [WIDTH-1:0]   val;
    byp_sel_e           sel;

    assign a = bus.ra[lane_lo(i, REGBITS) +: REGBITS];

    // Reset also masks the bypass so rd reads zero while reset is held.
    always_comb begin
      sel = BYP_RAM;
      if (reset || (ZERO_REG && (a == '0)))          sel = BYP_ZERO;
      else if (BYPASS && wr1_ok && (bus.wa1 == a))   sel = BYP_WD1;
      else if (BYPASS && wr0_ok && (bus.wa0 == a))   sel = BYP_WD0;
    end

    always_comb begin
      val = '0;
      unique case (sel)
        BYP_RAM:  val = ram_q[a];
        BYP_WD0:  val = bus.wd0;
        BYP_WD1:  val = bus.wd1;
        BYP_ZERO: val = '0;
        default:  val = '0;
      endcase
    end

    assign bus.rd[i*WIDTH +: WIDTH] = val;
  end

  regfile_scoreboard #(
    .REGBITS  (REGBITS),
    .NREAD    (NREAD),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .we0_i      (bus.we0),
    .wa0_i      (bus.wa0),
    .we1_i      (bus.we1),
    .wa1_i      (bus.wa1),
    .issue_i    (bus.issue),
    .issue_wa_i (bus.issue_wa),
    .ra_i       (bus.ra),
    .busy_o     (bus.busy),
    .pend_cnt_o (bus.pend_cnt)
  );

endmodule
